// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the core-to-APB bridge.
package apb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} apb_state_e;

   localparam int APB_SLOT_BITS = 12;
   localparam int APB_IDX_LSB   = 12;
   localparam int APB_IDX_MSB   = 15;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Core-side request/response signals plus the shared APB bus, bundled for the bridge.
interface apb_master_ctrl_if #(
   parameter int NUM_SLAVES = 4
) ();

   logic                       transfer;
   logic                       write;
   logic [31:0]                addr;
   logic [31:0]                wdata;
   logic [31:0]                rdata;
   logic                       ready;
   logic                       error;

   logic [31:0]                PADDR;
   logic [31:0]                PWDATA;
   logic                       PWRITE;
   logic                       PENABLE;
   logic [NUM_SLAVES-1:0]      PSEL;
   logic [NUM_SLAVES*32-1:0]   PRDATA;
   logic [NUM_SLAVES-1:0]      PREADY;
   logic [NUM_SLAVES-1:0]      PSLVERR;

   modport master (
      input  transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
      output rdata, ready, error, PADDR, PWDATA, PWRITE, PENABLE, PSEL
   );

   modport slave (
      output transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
      input  rdata, ready, error, PADDR, PWDATA, PWRITE, PENABLE, PSEL
   );

endinterface

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto one of NUM_SLAVES 4KB slots above BASE_ADDR.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic [31:APB_SLOT_BITS]  i_addr,
   output logic                     o_hit,
   output logic [NUM_SLAVES-1:0]    o_sel,
   output logic [3:0]               o_index
);

   always_comb begin
      o_index = i_addr[APB_IDX_MSB:APB_IDX_LSB];
      o_hit   = (i_addr[31:16] == BASE_ADDR[31:16]) &&
                ({28'd0, o_index} < 32'(NUM_SLAVES));
      o_sel   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         o_sel[i] = o_hit && (o_index == 4'(i));
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// Bridges the multicycle core's transfer/ready bus onto APB, with decode-error
// and PREADY-timeout completion so a request always finishes.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          TIMEOUT    = 16
) (
   input  logic               clk,
   input  logic               reset,
   apb_master_ctrl_if.master  bus
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   apb_state_e              r_state;
   apb_state_e              w_next;
   logic [31:0]             r_paddr;
   logic [31:0]             r_pwdata;
   logic                    r_pwrite;
   logic [31:0]             r_rdata;
   logic [NUM_SLAVES-1:0]   r_sel;
   logic [3:0]              r_idx;
   logic [CW-1:0]           r_cnt;

   logic                    w_hit;
   logic [NUM_SLAVES-1:0]   w_sel;
   logic [3:0]              w_index;
   logic                    w_pready;
   logic                    w_pslverr;
   logic [31:0]             w_prdata;
   logic                    w_ready;
   logic                    w_error;
   logic [31:0]             w_rdata;

   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_ADDR  (BASE_ADDR)
   ) u_dec (
      .i_addr  (bus.addr[31:APB_SLOT_BITS]),
      .o_hit   (w_hit),
      .o_sel   (w_sel),
      .o_index (w_index)
   );

   // Only the latched slave's response is looked at; the others may hold anything.
   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == 4'(i)) begin
            w_pready  = bus.PREADY[i];
            w_pslverr = bus.PSLVERR[i];
            w_prdata  = bus.PRDATA[32*i +: 32];
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_error = 1'b0;
      w_rdata = r_rdata;
      case (r_state)
         IDLE: begin
            if (bus.transfer) begin
               w_next = w_hit ? SETUP : DECERR;
            end
         end
         SETUP: begin
            w_next = ACCESS;
         end
         ACCESS: begin
            if (w_pready) begin
               w_ready = 1'b1;
               w_error = w_pslverr;
               w_rdata = w_prdata;
               w_next  = IDLE;
            end else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_ready = 1'b1;
               w_error = 1'b1;
               w_rdata = '0;
               w_next  = IDLE;
            end
         end
         DECERR: begin
            w_ready = 1'b1;
            w_error = 1'b1;
            w_rdata = '0;
            w_next  = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      // A reset edge aborts the transaction, so no completion may escape this cycle.
      if (reset) begin
         w_ready = 1'b0;
         w_error = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_pwrite <= 1'b0;
         r_rdata  <= '0;
         r_sel    <= '0;
         r_idx    <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && bus.transfer) begin
            r_paddr  <= bus.addr;
            r_pwdata <= bus.wdata;
            r_pwrite <= bus.write;
            r_sel    <= w_sel;
            r_idx    <= w_index;
         end
         if (w_next == SETUP) begin
            r_cnt <= '0;
         end else if (r_state == ACCESS && !w_pready) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_ready) begin
            r_rdata <= w_rdata;
         end
      end
   end

   assign bus.PSEL    = (r_state == SETUP || r_state == ACCESS) ? r_sel : '0;
   assign bus.PENABLE = (r_state == ACCESS);
   assign bus.PADDR   = r_paddr;
   assign bus.PWDATA  = r_pwdata;
   assign bus.PWRITE  = r_pwrite;
   assign bus.rdata   = w_rdata;
   assign bus.ready   = w_ready;
   assign bus.error   = w_error;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_apb_master_ctrl;

   localparam int NS = 4;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        pwrite;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   start_cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   acc_cnt = 0;
   int   s_wait [NS];
   logic [31:0] s_data [NS];
   logic        s_err  [NS];
   exp_t sb_q [$];

   apb_master_ctrl_if #(.NUM_SLAVES(NS)) bus ();

   apb_master_ctrl #(
      .NUM_SLAVES (NS),
      .BASE_ADDR  (32'h1000_0000),
      .TIMEOUT    (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (reset || !bus.PENABLE || bus.ready) acc_cnt <= 0;
      else acc_cnt <= acc_cnt + 1;
   end

   // Slave model; unselected slaves present ready/error junk that must be ignored.
   always_comb begin
      bus.PREADY  = '1;
      bus.PSLVERR = '1;
      bus.PRDATA  = '0;
      for (int i = 0; i < NS; i++) begin
         bus.PRDATA[32*i +: 32] = s_data[i];
         if (bus.PSEL[i]) begin
            bus.PREADY[i]  = (s_wait[i] >= 0) && (acc_cnt >= s_wait[i]);
            bus.PSLVERR[i] = s_err[i];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      chk("psel_onehot", 32'(($countones(bus.PSEL) <= 1)), 32'd1);
      if (bus.ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ready", 32'(bus.ready), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rdata",   bus.rdata, e.rdata);
            chk("error",   32'(bus.error), 32'(e.err));
            chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
            chk("paddr",   bus.PADDR, e.paddr);
            chk("pwdata",  bus.PWDATA, e.pwdata);
            chk("pwrite",  32'(bus.PWRITE), 32'(e.pwrite));
         end
      end
   end

   task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                         input logic [3:0] sel, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat, input bit idle_after);
      exp_t e;
      int   k;
      bit   done;
      @(posedge clk); #1;
      bus.transfer = 1'b1;
      bus.write    = wr;
      bus.addr     = a;
      bus.wdata    = wd;
      start_cyc    = cyc;
      e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
      e.paddr = a; e.pwdata = wd; e.pwrite = wr;
      sb_q.push_back(e);
      k = 0;
      done = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         if (k == 0 || sel == 4'd0) begin
            chk("psel_phase", 32'(bus.PSEL), 32'd0);
            chk("penable_phase", 32'(bus.PENABLE), 32'd0);
         end else begin
            chk("psel_phase", 32'(bus.PSEL), 32'(sel));
            chk("penable_phase", 32'(bus.PENABLE), (k == 1) ? 32'd0 : 32'd1);
         end
         if (bus.ready === 1'b1) begin
            done = 1;
         end else begin
            @(posedge clk); #1;
            if (k == 0) begin
               bus.addr  = ~a;
               bus.wdata = ~wd;
            end
            k++;
         end
      end
      if (!done) chk("ready_wait", 32'd0, 32'd1);
      if (idle_after) begin
         @(posedge clk); #1;
         bus.transfer = 1'b0;
         @(negedge clk);
         chk("psel_after", 32'(bus.PSEL), 32'd0);
         chk("penable_after", 32'(bus.PENABLE), 32'd0);
         chk("ready_after", 32'(bus.ready), 32'd0);
         chk("rdata_held", bus.rdata, exp_rd);
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         s_wait[i] = 0;
         s_err[i]  = 1'b0;
      end
      s_data[0] = 32'h0A0A_0A0A;
      s_data[1] = 32'h1111_1111;
      s_data[2] = 32'h1234_5678;
      s_data[3] = 32'h3333_3333;
      reset        = 1'b1;
      bus.transfer = 1'b0;
      bus.write    = 1'b0;
      bus.addr     = '0;
      bus.wdata    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", 32'(bus.PSEL), 32'd0);
      chk("rst_penable", 32'(bus.PENABLE), 32'd0);
      chk("rst_paddr", bus.PADDR, 32'd0);
      chk("rst_pwdata", bus.PWDATA, 32'd0);
      chk("rst_pwrite", 32'(bus.PWRITE), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // zero-wait write to slave 1
      do_txn(32'h1000_1004, 32'hDEAD_BEEF, 1'b1, 4'b0010, 32'h1111_1111, 1'b0, 2, 1);
      // slave 2 read with three wait states
      s_wait[2] = 3;
      do_txn(32'h1000_2000, 32'h0, 1'b0, 4'b0100, 32'h1234_5678, 1'b0, 5, 1);
      // unmapped region and out-of-range slot index
      do_txn(32'h2000_0000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 1, 1);
      do_txn(32'h1000_4000, 32'h5555_0000, 1'b1, 4'b0000, 32'h0, 1'b1, 1, 1);
      // slave 0 never ready: timeout after 16 ACCESS cycles
      s_wait[0] = -1;
      do_txn(32'h1000_0010, 32'h0, 1'b0, 4'b0001, 32'h0, 1'b1, 17, 1);
      // PREADY on the last allowed ACCESS cycle still completes normally
      s_wait[0] = 15;
      do_txn(32'h1000_0FFC, 32'h0, 1'b0, 4'b0001, 32'h0A0A_0A0A, 1'b0, 17, 1);
      // slave error, then a back-to-back write
      s_wait[3] = 1;
      s_err[3]  = 1'b1;
      do_txn(32'h1000_3008, 32'h0, 1'b0, 4'b1000, 32'h3333_3333, 1'b1, 3, 0);
      do_txn(32'h1000_1ABC, 32'hCAFE_0001, 1'b1, 4'b0010, 32'h1111_1111, 1'b0, 2, 1);

      // reset in ACCESS while the slave answers: no completion may appear
      s_wait[2] = -1;
      @(posedge clk); #1;
      bus.transfer = 1'b1;
      bus.write    = 1'b0;
      bus.addr     = 32'h1000_2010;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
      @(posedge clk); #1;
      reset        = 1'b1;
      bus.transfer = 1'b0;
      s_wait[2]    = 0;
      @(negedge clk);
      chk("rst_mid_ready", 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_psel", 32'(bus.PSEL), 32'd0);
      chk("rst_mid_penable", 32'(bus.PENABLE), 32'd0);
      chk("rst_mid_paddr", bus.PADDR, 32'd0);
      chk("rst_mid_rdata", bus.rdata, 32'd0);
      do_txn(32'h1000_2020, 32'h0, 1'b0, 4'b0100, 32'h1234_5678, 1'b0, 2, 1);

      repeat (3) @(posedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

endmodule
